// File: rtl/simple_ser_pkg_v.sv
// Shared definitions for the simple serial transmitter/receiver pair:
// line state encoding, idle line level and a constant-safe clog2.
package simple_ser_pkg_v;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/simple_ser_baud_v.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each serial bit.
module simple_ser_baud_v
    import simple_ser_pkg_v::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int unsigned CntW = (clog2(DIV) > 0) ? clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == CntMax);

endmodule

// File: rtl/simple_ser_tx_v.sv
// Parallel-to-serial transmitter: valid/ready word in, start + LSB-first data + stop out.
module simple_ser_tx_v
    import simple_ser_pkg_v::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV    = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] d_in,
    input  logic              d_vld,
    output logic              d_rdy,
    output logic              tx,
    output logic              busy
);

    localparam int unsigned BitW = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;
    localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              baud_clr;
    logic              bit_end;

    // Divider held at zero while idle so the start bit gets a full period.
    assign baud_clr = (state_q == IDLE);

    simple_ser_baud_v #(
        .DIV(DIV)
    ) u_baud (
        .clk      (clk),
        .resetn   (resetn),
        .clr_i    (baud_clr),
        .bit_end_o(bit_end)
    );

    // Outputs are computed for the next state so they come straight from flops.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        rdy_d     = rdy_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (d_vld) begin
                    shreg_d = d_in;
                    state_d = START;
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BitMax) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        tx_d      = IDLE_LEVEL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shreg_d[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= IDLE_LEVEL;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign tx    = tx_q;
    assign d_rdy = rdy_q;
    assign busy  = busy_q;

endmodule

// File: doc/simple_ser_tx_v.md
Name: simple_ser_tx_v

Overview:
Parallel-to-serial transmitter: accepts an 8-bit word over a valid/ready handshake and shifts it out on a single line as one frame. The frame is a start bit, the data bits LSB first, then a stop bit.
It is the output end of a registered parallel data path, driving a serial link toward a matching receiver.
Bit timing comes from an internal clock-divider counter; there is no external baud tick.

Parameters:
DATA_W, 8, width of the parallel data word (bits per frame payload)
DIV, 4, clock cycles per serial bit; legal range 1..65535

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
d_in  input  DATA_W  parallel data word to transmit
d_vld  input  1  d_in is valid
d_rdy  output  1  transmitter can accept a word; transfer occurs when d_vld && d_rdy at a rising edge
tx  output  1  serial line; idle level 1
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is asynchronous, active-low.
- Reset values (applied immediately on resetn=0):
  - tx=1, d_rdy=1, busy=0
  - state=IDLE, bit counter=0, divider=0, shift register=0
- All outputs are registered; no combinational path from d_vld/d_in to any output.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - d_rdy=1, tx=1, busy=0.
  - On d_vld=1, d_in is loaded into the shift register, divider cleared, state goes to START.
  - d_rdy=0 and busy=1 from the next cycle.
- START:
  - tx=0 for exactly DIV cycles, then DATA with bit counter=0.
- DATA:
  - tx = shift register bit 0, held DIV cycles per bit.
  - At the end of each bit period: shift right by 1, bit counter +1.
  - After bit DATA_W-1 completes, go to STOP.
- STOP:
  - tx=1 for DIV cycles, then IDLE.
- Divider:
  - Counts 0..DIV-1; the end of a bit period is divider==DIV-1, after which it wraps to 0.
  - DIV=1: every cycle is a bit boundary.
- Timing:
  - The first tx=0 cycle is the cycle after acceptance.
  - Frame length is exactly (DATA_W+2)*DIV cycles.
  - d_rdy is 1 again the cycle after STOP ends.
  - With d_vld held high, frames repeat every (DATA_W+2)*DIV+1 cycles, with one idle cycle of tx=1 between frames.
- Data capture: d_in is sampled only at acceptance. Changes to d_in or d_vld during a frame are ignored.
- d_vld without d_rdy: no effect; the word stays pending at the source.
- Reset mid-frame: the frame is aborted and tx returns to 1 asynchronously. No partial frame resumes after reset release.
- Widths:
  - Bit counter is clog2(DATA_W) bits wide and never exceeds DATA_W-1.
  - Divider is clog2(DIV) bits wide, minimum 1.

Decomposition:
- Package simple_ser_pkg_v holds:
  - state encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - the idle line level constant (1'b1)
  - the clog2 helper function
- The matching receiver reuses the same package.
- One sub-module, simple_ser_baud_v:
  - DIV-cycle counter with a synchronous clear input and a one-cycle end-of-bit output.
  - Async active-low reset on clk/resetn.
- The FSM and shift register stay in the top module.

Test Plan:
1. Reset check: resetn=0 with random d_in/d_vld -> tx=1, d_rdy=1, busy=0 throughout; all remain so 5 cycles after release with d_vld=0.
2. Single frame, DIV=4, d_in=8'hA5 pulsed with d_vld for 1 cycle:
   - tx sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
   - d_rdy=0 for exactly 40 cycles.
3. Back-to-back, DIV=4, d_vld held high, words 8'h00 then 8'hFF:
   - Second start bit begins 41 cycles after the first.
   - Payload bits are all 0 in frame 1, all 1 in frame 2.
   - Exactly one idle cycle of tx=1 between frames.
4. Data stability, DIV=4, send 8'h3C, change d_in to 8'hC3 mid-frame -> transmitted bits still encode 8'h3C (0,0,1,1,1,1,0,0 LSB first).
5. DIV=1 corner, send 8'h81 -> tx = 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; d_rdy returns 1 on cycle 11.
6. Reset mid-frame: assert resetn=0 during data bit 3 of 8'h55 -> tx=1 immediately; after release, d_rdy=1 and the next frame with 8'h0F is transmitted correctly.
